// File: rtl/poly_tone_pkg.sv
// Shared definitions for the polyphonic tone sequencer: FSM states and
// step-word field placement helpers.
package poly_tone_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } state_e;

  // Step word: {end, length, period[CHANNELS-1], ..., period[0]}
  function automatic int step_width(input int channels, input int period_w, input int len_w);
    return channels * period_w + len_w + 1;
  endfunction

  function automatic int end_bit(input int channels, input int period_w, input int len_w);
    return step_width(channels, period_w, len_w) - 1;
  endfunction

  function automatic int len_msb(input int channels, input int period_w, input int len_w);
    return step_width(channels, period_w, len_w) - 2;
  endfunction

endpackage

// File: rtl/poly_tone_voice.sv
// One square-wave voice: period register, half-period down-counter and
// toggle flop. Exposes its next output so the top can register it gated.
module poly_tone_voice #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tone_d
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tone_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    tone_d   = tone_q;
    if (load) begin
      period_d = period;
      cnt_d    = (period == '0) ? '0 : period - ONE;
      tone_d   = 1'b0;
    end else if (run && (period_q != '0)) begin
      if (cnt_q == '0) begin
        tone_d = ~tone_q;
        cnt_d  = period_q - ONE;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      cnt_q    <= '0;
      tone_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tone_q   <= tone_d;
    end
  end

endmodule

// File: rtl/poly_tone_sequencer.sv
// Multi-channel square-wave tune player: walks a step memory, drives one
// voice per channel for (L+1)*(tempo+1) cycles per step.
module poly_tone_sequencer
  import poly_tone_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PERIOD_W = 8,
  parameter int LEN_W    = 4,
  parameter int ADDR_W   = 8,
  parameter int TEMPO_W  = 12,
  localparam int STEP_W  = step_width(CHANNELS, PERIOD_W, LEN_W),
  localparam int MIX_W   = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [TEMPO_W-1:0]  tempo,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [STEP_W-1:0]   rom_data,
  output logic [CHANNELS-1:0] speaker,
  output logic [MIX_W-1:0]    mix,
  output logic                busy,
  output logic                done
);

  localparam int END_BIT = end_bit(CHANNELS, PERIOD_W, LEN_W);
  localparam int LEN_MSB = len_msb(CHANNELS, PERIOD_W, LEN_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TEMPO_W-1:0]  presc_q, presc_d;
  logic [LEN_W-1:0]    beats_q, beats_d;
  logic [CHANNELS-1:0] speaker_q, speaker_d, tone_d;
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic                done_q, done_d;
  logic                voice_load, voice_run;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    presc_d    = presc_q;
    beats_d    = beats_q;
    done_d     = 1'b0;
    voice_load = 1'b0;
    voice_run  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_d = '0;
          if (start) state_d = FETCH;
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (rom_data[END_BIT]) begin
            addr_d = '0;
            if (loop_en) begin
              state_d = FETCH;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            voice_load = 1'b1;
            beats_d    = rom_data[LEN_MSB -: LEN_W];
            presc_d    = tempo;
            state_d    = PLAY;
          end
        end
        PLAY: begin
          voice_run = 1'b1;
          if (presc_q != '0) begin
            presc_d = presc_q - TEMPO_W'(1);
          end else if (beats_q != '0) begin
            // Beat boundary: tempo is re-sampled here so changes take effect next beat.
            beats_d = beats_q - LEN_W'(1);
            presc_d = tempo;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    poly_tone_voice #(.PERIOD_W(PERIOD_W)) u_voice (
      .clk    (clk),
      .reset  (reset),
      .load   (voice_load),
      .run    (voice_run),
      .period (rom_data[g*PERIOD_W +: PERIOD_W]),
      .tone_d (tone_d[g])
    );
  end

  // Speaker and mix are registered from the same gated next value so they always agree.
  always_comb begin
    speaker_d = (state_d == PLAY) ? tone_d : '0;
    mix_d     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mix_d = mix_d + MIX_W'(speaker_d[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      presc_q   <= '0;
      beats_q   <= '0;
      speaker_q <= '0;
      mix_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      presc_q   <= presc_d;
      beats_q   <= beats_d;
      speaker_q <= speaker_d;
      mix_q     <= mix_d;
      done_q    <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign speaker  = speaker_q;
  assign mix      = mix_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule
